// File: rtl/rx_ltssm_qualifier_if.sv
// Bundle between the main LTSSM (master) and the RX qualifier (slave).
interface rx_ltssm_qualifier_if #(
    parameter int MAXLANES = 16
);
    logic                req_valid;
    logic [4:0]          substate;
    logic [5:0]          lane_width;
    logic [MAXLANES-1:0] os_hit;
    logic                rx_eidle_exit;
    logic [2:0]          train_to_gen;
    logic                rcvr_cfg_to_idle;
    logic                eq_redo;
    logic                done;
    logic [4:0]          exit_to;
    logic [MAXLANES-1:0] qualified_lanes;
    logic                os_chk_clr;
    logic                descrambler_en;
    logic                timed_out;

    modport master (
        output req_valid, substate, lane_width, os_hit, rx_eidle_exit,
               train_to_gen, rcvr_cfg_to_idle, eq_redo,
        input  done, exit_to, qualified_lanes, os_chk_clr, descrambler_en, timed_out
    );

    modport slave (
        input  req_valid, substate, lane_width, os_hit, rx_eidle_exit,
               train_to_gen, rcvr_cfg_to_idle, eq_redo,
        output done, exit_to, qualified_lanes, os_chk_clr, descrambler_en, timed_out
    );
endinterface

// File: rtl/rx_ltssm_qualifier.sv
// RX-side LTSSM qualifier: per request, counts expected ordered sets per lane
// against a per-substate threshold under an internal ms timer, then reports
// done / exit substate / qualified-lane mask and gates the descrambler.
// Optional feature macro: RX_QUAL_PARTIAL_LANE_EN (turns a lane-counting
// failure into a reduced-width pass when a power-of-two lane prefix qualified).
module rx_ltssm_qualifier #(
    parameter int MAXLANES   = 16,
    parameter int CLK_PER_MS = 250000,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    rx_ltssm_qualifier_if.slave bus
);
    localparam int                 PRESC_W   = $clog2(CLK_PER_MS);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);

    localparam logic [4:0] DETECT_QUIET  = 5'd0;
    localparam logic [4:0] DETECT_ACTIVE = 5'd1;
    localparam logic [4:0] POLL_ACTIVE   = 5'd2;
    localparam logic [4:0] POLL_CFG      = 5'd3;
    localparam logic [4:0] CFG_LW_START  = 5'd4;
    localparam logic [4:0] CFG_LW_ACCEPT = 5'd5;
    localparam logic [4:0] CFG_LN_WAIT   = 5'd6;
    localparam logic [4:0] CFG_LN_ACCEPT = 5'd7;
    localparam logic [4:0] CFG_COMPLETE  = 5'd8;
    localparam logic [4:0] CFG_IDLE      = 5'd9;
    localparam logic [4:0] L0            = 5'd10;
    localparam logic [4:0] REC_RCVR_LOCK = 5'd11;
    localparam logic [4:0] REC_RCVR_CFG  = 5'd12;
    localparam logic [4:0] REC_SPEED     = 5'd13;
    localparam logic [4:0] PHASE0        = 5'd14;
    localparam logic [4:0] PHASE1        = 5'd15;
    localparam logic [4:0] PHASE2        = 5'd16;
    localparam logic [4:0] PHASE3        = 5'd17;
    localparam logic [4:0] REC_IDLE      = 5'd18;

    typedef enum logic [1:0] {IDLE, COUNT, PASS, FAIL} state_t;

    state_t                         state, stateNext;
    logic [4:0]                     subLat;
    logic [5:0]                     widthLat;
    logic [PRESC_W-1:0]             presc;
    logic [5:0]                     msCnt;
    logic [MAXLANES-1:0][CNT_W-1:0] laneCnt, cntNext;
    logic [MAXLANES-1:0]            qual, laneMask, qualReg, resLanes;
    logic [4:0]                     exitReg, resExit, passExit;
    logic                           timedReg, resTimed, loadRes, descrEn;
    logic                           listed, hasThr, widthOk, timeout, allq;
    logic [CNT_W-1:0]               thr;
    logic [5:0]                     limit;

    // Threshold / timeout lookup for the latched substate.
    always_comb begin
        listed = 1'b1;
        hasThr = 1'b1;
        thr    = CNT_W'(2);
        limit  = 6'd24;
        case (subLat)
            DETECT_QUIET:  begin hasThr = 1'b0; limit = 6'd12; end
            DETECT_ACTIVE: begin hasThr = 1'b0; limit = 6'd0;  end
            POLL_ACTIVE, CFG_COMPLETE: thr = CNT_W'(8);
            CFG_LW_START, CFG_LW_ACCEPT, CFG_LN_ACCEPT,
            PHASE0, PHASE1, PHASE2, PHASE3: begin end
            CFG_LN_WAIT, CFG_IDLE: limit = 6'd2;
            POLL_CFG, REC_RCVR_LOCK, REC_RCVR_CFG: begin thr = CNT_W'(8); limit = 6'd48; end
            REC_SPEED:     begin thr = CNT_W'(1); limit = 6'd1; end
            default:       begin listed = 1'b0; hasThr = 1'b0; end
        endcase
    end

    assign widthOk = (widthLat == 6'd1 || widthLat == 6'd2 || widthLat == 6'd4 ||
                      widthLat == 6'd8 || widthLat == 6'd16 || widthLat == 6'd32) &&
                     (int'(widthLat) <= MAXLANES);

    // Per-lane saturating count including this cycle's hits, so a lane that
    // reaches threshold now can finish the request on this very cycle.
    always_comb begin
        for (int l = 0; l < MAXLANES; l++) begin
            cntNext[l] = laneCnt[l];
            if (bus.os_hit[l] && (laneCnt[l] != {CNT_W{1'b1}}))
                cntNext[l] = laneCnt[l] + 1'b1;
            qual[l]     = hasThr && (cntNext[l] >= thr);
            laneMask[l] = widthOk && (l < int'(widthLat));
        end
    end

    assign allq    = (laneMask != '0) && ((qual & laneMask) == laneMask);
    assign timeout = (msCnt == limit);

    // Exit substate on a pass, highest-priority rule first.
    always_comb begin
        if (bus.rcvr_cfg_to_idle && subLat == REC_RCVR_CFG)   passExit = REC_IDLE;
        else if (subLat == PHASE1 && bus.eq_redo)            passExit = REC_RCVR_LOCK;
        else if (subLat == REC_IDLE)                         passExit = L0;
        else if (subLat == REC_SPEED && bus.train_to_gen != 3'd3) passExit = REC_RCVR_LOCK;
        else                                                 passExit = subLat + 5'd1;
    end

`ifdef RX_QUAL_PARTIAL_LANE_EN
    logic [MAXLANES-1:0] partLanes, lowBits;

    // Widest power-of-two lane prefix that fully qualified (zero if lane 0 did not).
    always_comb begin
        partLanes = '0;
        lowBits   = '0;
        for (int p = 1; p <= MAXLANES; p = p * 2) begin
            for (int l = 0; l < MAXLANES; l++) lowBits[l] = (l < p);
            if (((qual & laneMask) & lowBits) == lowBits) partLanes = lowBits;
        end
    end
`endif

    // Next state and result capture; results are loaded on entry to PASS/FAIL.
    always_comb begin
        stateNext = state;
        loadRes   = 1'b0;
        resExit   = DETECT_QUIET;
        resLanes  = qual & laneMask;
        resTimed  = 1'b0;
        case (state)
            IDLE: if (bus.req_valid && bus.substate != L0) stateNext = COUNT;
            COUNT: begin
                if (!listed) begin
                    stateNext = FAIL; loadRes = 1'b1; resTimed = 1'b1;
                end else if (subLat == DETECT_QUIET || subLat == DETECT_ACTIVE) begin
                    if (timeout || (subLat == DETECT_QUIET && bus.rx_eidle_exit)) begin
                        stateNext = PASS; loadRes = 1'b1; resExit = passExit;
                    end
                end else if (allq && (subLat != REC_SPEED || timeout)) begin
                    stateNext = PASS; loadRes = 1'b1; resExit = passExit;
                end else if (timeout) begin
                    stateNext = FAIL; loadRes = 1'b1; resTimed = 1'b1;
`ifdef RX_QUAL_PARTIAL_LANE_EN
                    if (partLanes != '0) begin
                        stateNext = PASS;
                        resExit   = passExit;
                        resLanes  = partLanes;
                    end
`endif
                end
            end
            PASS, FAIL: stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    // State, request latch, timer, lane counters and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            subLat   <= '0;
            widthLat <= '0;
            presc    <= '0;
            msCnt    <= '0;
            laneCnt  <= '0;
            exitReg  <= '0;
            qualReg  <= '0;
            timedReg <= 1'b0;
            descrEn  <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && bus.req_valid) begin
                if (bus.substate == L0) begin
                    descrEn <= 1'b1;
                end else begin
                    descrEn  <= 1'b0;
                    subLat   <= bus.substate;
                    widthLat <= bus.lane_width;
                    presc    <= '0;
                    msCnt    <= '0;
                    laneCnt  <= '0;
                end
            end
            if (state == COUNT) begin
                laneCnt <= cntNext;
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    msCnt <= msCnt + 6'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            if (loadRes) begin
                exitReg  <= resExit;
                qualReg  <= resLanes;
                timedReg <= resTimed;
            end
        end
    end

    assign bus.done            = (state == PASS) || (state == FAIL);
    assign bus.exit_to         = exitReg;
    assign bus.qualified_lanes = qualReg;
    assign bus.os_chk_clr      = (state != COUNT);
    assign bus.descrambler_en  = descrEn;
    assign bus.timed_out       = timedReg && bus.done;
endmodule

// File: tb/tb_rx_ltssm_qualifier.sv
// Randomized scoreboard bench for rx_ltssm_qualifier: stimulus pushes the
// expected result (including its done cycle) from a behavioural model; a
// negedge monitor pops and compares on every done pulse.
module tb_rx_ltssm_qualifier;
    localparam int ML  = 16;
    localparam int CPM = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        int            cycle;
        logic [4:0]    ex;
        logic [ML-1:0] lanes;
        logic          to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nChk = 0;
    int   nPass = 0;
    exp_t expQ[$];
    exp_t e;
    int   tgt[ML];
    int   thrTab[19] = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 2, 0, 8, 8, 1, 2, 2, 2, 2, 0};
    int   limTab[19] = '{12, 0, 24, 48, 24, 24, 2, 24, 24, 2, 0, 48, 48, 1, 24, 24, 24, 24, 0};
    int   widths[7]  = '{1, 2, 4, 8, 16, 32, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_ltssm_qualifier_if #(.MAXLANES(ML)) bus ();
    rx_ltssm_qualifier #(.MAXLANES(ML), .CLK_PER_MS(CPM), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nChk++;
        if (act === req) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    // Listed substates: codes 0..17 except L0 (recoveryIdle has no table entry).
    function automatic bit isListed(input int s);
        return (s >= 0 && s <= 17 && s != 10);
    endfunction

    function automatic int passExitM(input int s, input int gen, input bit ci, input bit er);
        if (ci && s == 12) return 18;
        if (s == 15 && er) return 11;
        if (s == 18) return 10;
        if (s == 13 && gen != 3) return 11;
        return s + 1;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (expQ.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = expQ.pop_front();
                chk("done_cycle", cyc, e.cycle);
                chk("exit_to", 32'(bus.exit_to), 32'(e.ex));
                chk("qualified_lanes", 32'(bus.qualified_lanes), 32'(e.lanes));
                chk("timed_out", 32'(bus.timed_out), 32'(e.to));
            end
        end
    end

    task automatic setTgt(input int n, input int v);
        for (int l = 0; l < ML; l++) tgt[l] = (l < n) ? v : 0;
    endtask

    task automatic runReq(input int sub, input int width, input int gen, input bit ci,
                          input bit er, input int eidleAt, input int prob);
        int            cnt[ML];
        int            rem[ML];
        logic [ML-1:0] m, q, hit, lo;
        bit            fin, pass, fail, allq, to, wOk;
        int            k, c0, best;
        exp_t          x;
        wOk = (width == 1 || width == 2 || width == 4 || width == 8 || width == 16 || width == 32)
              && width <= ML;
        for (int l = 0; l < ML; l++) begin
            m[l] = wOk && (l < width);
            cnt[l] = 0;
            rem[l] = tgt[l];
        end
        bus.req_valid = 1'b1; bus.substate = 5'(sub); bus.lane_width = 6'(width);
        bus.train_to_gen = 3'(gen); bus.rcvr_cfg_to_idle = ci; bus.eq_redo = er;
        bus.os_hit = '0; bus.rx_eidle_exit = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("os_chk_clr_count", 32'(bus.os_chk_clr), 32'd0);
        chk("descrambler_off", 32'(bus.descrambler_en), 32'd0);
        c0 = cyc; k = 0; fin = 0;
        while (!fin) begin
            hit = '0;
            for (int l = 0; l < ML; l++) begin
                if (rem[l] > 0 && $urandom_range(0, 99) < prob) begin
                    hit[l] = 1'b1; rem[l]--;
                    if (cnt[l] < SAT) cnt[l]++;
                end
            end
            bus.os_hit = hit;
            bus.rx_eidle_exit = (k == eidleAt);
            q = '0;
            if (isListed(sub) && thrTab[sub] > 0)
                for (int l = 0; l < ML; l++) q[l] = (cnt[l] >= thrTab[sub]);
            allq = (m != '0) && ((q & m) == m);
            to = isListed(sub) && (k >= limTab[sub] * CPM);
            pass = 0; fail = 0;
            if (!isListed(sub))          fail = 1;
            else if (sub == 0)           pass = (k == eidleAt) || to;
            else if (sub == 1)           pass = to;
            else if (sub == 13)          begin pass = to && allq; fail = to && !allq; end
            else if (allq)               pass = 1;
            else if (to)                 fail = 1;
            if (pass || fail) begin
                fin = 1;
                x.cycle = c0 + k + 1;
                x.lanes = q & m;
                x.ex = pass ? 5'(passExitM(sub, gen, ci, er)) : 5'd0;
                x.to = fail;
`ifdef RX_QUAL_PARTIAL_LANE_EN
                if (fail && isListed(sub) && thrTab[sub] > 0) begin
                    best = 0;
                    for (int p = 1; p <= ML; p = p * 2) begin
                        for (int l = 0; l < ML; l++) lo[l] = (l < p);
                        if (((q & m) & lo) == lo) best = p;
                    end
                    if (best >= 1) begin
                        for (int l = 0; l < ML; l++) lo[l] = (l < best);
                        x.ex = 5'(passExitM(sub, gen, ci, er));
                        x.lanes = lo;
                    end
                end
`else
                best = 0; lo = '0;
`endif
                expQ.push_back(x);
            end
            @(posedge clk); #1;
            k++;
            if (k > 2000) begin
                chk("request_bound", 32'(k), 32'd2000);
                fin = 1;
            end
        end
        bus.os_hit = '0; bus.rx_eidle_exit = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int s, w, n;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.substate = '0; bus.lane_width = '0; bus.os_hit = '0;
        bus.rx_eidle_exit = 1'b0; bus.train_to_gen = '0; bus.rcvr_cfg_to_idle = 1'b0;
        bus.eq_redo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_exit_to", 32'(bus.exit_to), 32'd0);
        chk("rst_qual", 32'(bus.qualified_lanes), 32'd0);
        chk("rst_os_chk_clr", 32'(bus.os_chk_clr), 32'd1);
        chk("rst_descr", 32'(bus.descrambler_en), 32'd0);
        chk("rst_timed_out", 32'(bus.timed_out), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        setTgt(4, 8);  runReq(2, 4, 2, 0, 0, -1, 100);     // pollingActive x4
        setTgt(8, 8); tgt[7] = 7; runReq(11, 8, 2, 0, 0, -1, 100); // recRcvrLock, lane 7 short
        setTgt(0, 0);  runReq(0, 4, 2, 0, 0, 10, 100);     // detectQuiet, eidle exit
        setTgt(0, 0);  runReq(1, 4, 2, 0, 0, -1, 100);     // detectActive
        setTgt(1, 1);  runReq(13, 1, 2, 0, 0, -1, 100);    // recSpeed gen2
        setTgt(1, 1);  runReq(13, 1, 3, 0, 0, -1, 100);    // recSpeed gen3
        setTgt(2, 8);  runReq(12, 2, 2, 1, 0, -1, 100);    // recRcvrCfg to idle
        setTgt(4, 2);  runReq(15, 4, 2, 0, 1, -1, 100);    // phase1 re-lock
        setTgt(4, 9);  runReq(20, 4, 2, 0, 0, -1, 100);    // unlisted code
        setTgt(16, 3); runReq(9, 3, 2, 0, 0, -1, 100);     // unsupported width

        // L0 request: descrambler on, no done.
        bus.req_valid = 1'b1; bus.substate = 5'd10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("l0_descr_on", 32'(bus.descrambler_en), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of COUNT: reset values, no done afterwards.
        bus.req_valid = 1'b1; bus.substate = 5'd11; bus.lane_width = 6'd4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_count", 32'(bus.os_chk_clr), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_exit_to", 32'(bus.exit_to), 32'd0);
        chk("mid_rst_qual", 32'(bus.qualified_lanes), 32'd0);
        chk("mid_rst_os_chk_clr", 32'(bus.os_chk_clr), 32'd1);
        chk("mid_rst_descr", 32'(bus.descrambler_en), 32'd0);
        chk("mid_rst_timed_out", 32'(bus.timed_out), 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        for (int r = 0; r < 30; r++) begin
            s = $urandom_range(0, 31);
            if (s == 10) s = 2;
            w = widths[$urandom_range(0, 6)];
            for (int l = 0; l < ML; l++) begin
                n = $urandom_range(0, 20);
                tgt[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : n;
            end
            runReq(s, w, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 150), $urandom_range(20, 100));
        end

        for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end
endmodule
